// File: rtl/sync_fifo_flagged.sv
// ---------------------------------------------------------------------------
// sync_fifo_flagged
//
// Single-clock circular FIFO. DEPTH words of DATA_WIDTH bits are held in a
// RAM addressed by the low PTR_W bits of two (PTR_W+1)-bit pointers; the
// extra MSB tells a full FIFO apart from an empty one. Provides occupancy,
// programmable almost-full/almost-empty thresholds, sticky overflow and
// underflow flags, a synchronous flush, and an optional first-word-fall-
// through read port.
//
// Ports
//   clk_i           clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   flush_i         synchronous flush (priority over reads and writes)
//   wr_en_i/data_i  write request and data
//   rd_en_i/data_o  read request (acknowledge in FWFT mode) and data
//   full_o, almost_full_o, empty_o, almost_empty_o, count_o
//   overflow_o      sticky: write attempted while full
//   underflow_o     sticky: read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_flagged #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4,
    parameter int FWFT       = 0,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic [PTR_W:0]        count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [PTR_W:0] AF_LVL = (PTR_W+1)'(AF_THRESH);
    localparam logic [PTR_W:0] AE_LVL = (PTR_W+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come only from the registered pointers, so there is no
    // combinational path from the request inputs to any status output.
    assign count_o        = wr_ptr - rd_ptr;
    assign empty_o        = (wr_ptr == rd_ptr);
    assign full_o         = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                            (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign almost_full_o  = (count_o >= AF_LVL);
    assign almost_empty_o = (count_o <= AE_LVL);

    // A read at full does not make room for a same-cycle write, and a write
    // at empty does not feed a same-cycle read.
    assign wr_acc = wr_en_i && !full_o  && !flush_i;
    assign rd_acc = rd_en_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en_i && full_o)  overflow_o  <= 1'b1;
            if (rd_en_i && empty_o) underflow_o <= 1'b1;
        end
    end

    // RAM storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem[wr_ptr[PTR_W-1:0]] <= data_i;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is always presented; meaningless while empty.
            assign data_o = mem[rd_ptr[PTR_W-1:0]];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] data_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    data_q <= '0;
                end else if (flush_i) begin
                    data_q <= '0;
                end else if (rd_acc) begin
                    data_q <= mem[rd_ptr[PTR_W-1:0]];
                end
            end

            assign data_o = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flagged.sv
module tb_sync_fifo_flagged;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic          clk;
    logic          rst_n;

    // registered-read instance
    logic          flush, wr_en, rd_en;
    logic [DW-1:0] din, dout;
    logic          full, afull, empty, aempty, ovf, unf;
    logic [3:0]    count;

    // FWFT instance
    logic          f_flush, f_wr_en, f_rd_en;
    logic [DW-1:0] f_din, f_dout;
    logic          f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
    logic [3:0]    f_count;

    int total = 0;
    int bad   = 0;

    sync_fifo_flagged #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(AF),
                        .AE_THRESH(AE), .FWFT(0)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .wr_en_i(wr_en), .data_i(din), .full_o(full), .almost_full_o(afull),
        .rd_en_i(rd_en), .data_o(dout), .empty_o(empty),
        .almost_empty_o(aempty), .count_o(count),
        .overflow_o(ovf), .underflow_o(unf));

    sync_fifo_flagged #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(AF),
                        .AE_THRESH(AE), .FWFT(1)) dut_f (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(f_flush),
        .wr_en_i(f_wr_en), .data_i(f_din), .full_o(f_full),
        .almost_full_o(f_afull), .rd_en_i(f_rd_en), .data_o(f_dout),
        .empty_o(f_empty), .almost_empty_o(f_aempty), .count_o(f_count),
        .overflow_o(f_ovf), .underflow_o(f_unf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          fl, wr, rd;
        logic [DW-1:0] d;
        int            cnt;
        logic          ovf, unf;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fl, input logic wr, input logic rd,
                       input logic [DW-1:0] d, input int cnt,
                       input logic o, input logic u, input logic [DW-1:0] q);
        vec_t v;
        v.fl = fl; v.wr = wr; v.rd = rd; v.d = d; v.cnt = cnt;
        v.ovf = o; v.unf = u; v.dout = q;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // status word {count, empty, full, afull, aempty, ovf, unf}
    function automatic logic [9:0] exp_stat(input int c, input logic o,
                                            input logic u);
        return {4'(c), (c == 0), (c == DP), (c >= AF), (c <= AE), o, u};
    endfunction

    function automatic logic [9:0] got_stat();
        return {count, empty, full, afull, aempty, ovf, unf};
    endfunction

    task automatic step(input logic fl, input logic wr, input logic rd,
                        input logic [DW-1:0] d);
        @(negedge clk);
        flush = fl; wr_en = wr; rd_en = rd; din = d;
        @(posedge clk);
        #1;
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic fstep(input logic wr, input logic rd, input logic [DW-1:0] d);
        @(negedge clk);
        f_wr_en = wr; f_rd_en = rd; f_din = d;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] model[$];
        logic [DW-1:0] exp_d;
        int            sz;
        logic          w, r;

        flush = 0; wr_en = 0; rd_en = 0; din = '0;
        f_flush = 0; f_wr_en = 0; f_rd_en = 0; f_din = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stat", 32'(got_stat()), 32'(exp_stat(0, 0, 0)));
        check("reset_data", 32'(dout), 32'h0);
        check("reset_f_empty", 32'(f_empty), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // fill, overflow, drain
        for (int k = 1; k <= 8; k++) add(0, 1, 0, 8'(k), k, 0, 0, 8'h00);
        add(0, 1, 0, 8'hFF, 8, 1, 0, 8'h00);
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 8'h00, 8 - k, 1, 0, 8'(k));
        // underflow at empty keeps data_o
        add(0, 0, 1, 8'h00, 0, 1, 1, 8'h08);
        // simultaneous at count 4, then flush+write at count 5
        for (int k = 0; k < 4; k++) add(0, 1, 0, 8'(8'h10 + k), k + 1, 1, 1, 8'h08);
        add(0, 1, 1, 8'h14, 4, 1, 1, 8'h10);
        add(0, 1, 0, 8'h15, 5, 1, 1, 8'h10);
        add(1, 1, 0, 8'hEE, 0, 0, 0, 8'h00);
        // simultaneous at full
        for (int k = 0; k < 8; k++) add(0, 1, 0, 8'(8'h20 + k), k + 1, 0, 0, 8'h00);
        add(0, 1, 1, 8'h99, 7, 1, 0, 8'h20);
        add(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        // simultaneous at empty
        add(0, 1, 1, 8'h31, 1, 0, 1, 8'h00);
        add(0, 0, 1, 8'h00, 0, 0, 1, 8'h31);
        // flush with read at empty raises nothing
        add(1, 0, 1, 8'h00, 0, 0, 0, 8'h00);

        foreach (vecs[i]) begin
            step(vecs[i].fl, vecs[i].wr, vecs[i].rd, vecs[i].d);
            check($sformatf("vec%0d_stat", i), 32'(got_stat()),
                  32'(exp_stat(vecs[i].cnt, vecs[i].ovf, vecs[i].unf)));
            check($sformatf("vec%0d_data", i), 32'(dout), 32'(vecs[i].dout));
        end

        // wrap-around with 3..5 words in flight
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 8'(8'h40 + k));
            model.push_back(8'(8'h40 + k));
        end
        for (int i = 0; i < 30; i++) begin
            sz = model.size();
            w  = (sz < 5);
            r  = (sz > 3) && (i % 2 == 0);
            exp_d = dout;
            if (r) exp_d = model.pop_front();
            if (w) model.push_back(8'(8'h50 + i));
            step(0, w, r, 8'(8'h50 + i));
            check($sformatf("wrap%0d_count", i), 32'(count), 32'(model.size()));
            check($sformatf("wrap%0d_data", i), 32'(dout), 32'(exp_d));
        end
        while (model.size() > 0) begin
            exp_d = model.pop_front();
            step(0, 0, 1, 8'h00);
            check("wrap_drain_data", 32'(dout), 32'(exp_d));
        end
        check("wrap_empty", 32'(got_stat()), 32'(exp_stat(0, 0, 0)));

        // async reset mid-stream with count 5 and nonzero data_o
        for (int k = 0; k < 6; k++) step(0, 1, 0, 8'(8'h61 + k));
        step(0, 0, 1, 8'h00);
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'hFF); // count 8 now? 5+3
        step(0, 1, 0, 8'hFF); // overflow
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        check("pre_reset_stat", 32'(got_stat()), 32'(exp_stat(5, 1, 0)));
        check("pre_reset_data", 32'(dout), 32'h64);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_stat", 32'(got_stat()), 32'(exp_stat(0, 0, 0)));
        check("async_reset_data", 32'(dout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 8'h5A);
        check("post_reset_cnt", 32'(count), 32'h1);
        step(0, 0, 1, 8'h00);
        check("post_reset_data", 32'(dout), 32'h5A);
        check("post_reset_stat", 32'(got_stat()), 32'(exp_stat(0, 0, 0)));

        // FWFT
        fstep(1, 0, 8'hA5);
        check("fwft_empty", 32'(f_empty), 32'h0);
        check("fwft_data", 32'(f_dout), 32'hA5);
        fstep(1, 0, 8'hB6);
        check("fwft_hold", 32'(f_dout), 32'hA5);
        fstep(0, 1, 8'h00);
        check("fwft_next", 32'(f_dout), 32'hB6);
        check("fwft_cnt1", 32'(f_count), 32'h1);
        fstep(0, 1, 8'h00);
        check("fwft_empty_after", 32'(f_empty), 32'h1);
        check("fwft_unf", 32'(f_unf), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
